// File: rtl/control_ws_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_ws_pkg
// Description : Shared types and encodings for the control_ws sequencer.
//               The PAUSE states exist only when CONTROL_WS_PAUSE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package control_ws_pkg;

    typedef enum logic [4:0] {
        S_HALTED,
        S_FETCH,
        S_RD,
        S_DEC_IR,
        S_DISPATCH,
        S_ADD,
        S_AND,
        S_NOT,
        S_BR_TAKE,
        S_JMP,
        S_JSR_R7,
        S_JSR_OFF,
        S_JSRR_BASE,
        S_LDR_ADDR,
        S_LD_ADDR,
        S_STR_ADDR,
        S_ST_ADDR,
        S_LEA,
        S_ILLEGAL,
        S_LDREG,
        S_STDATA,
        S_WR
`ifdef CONTROL_WS_PAUSE_EN
        ,
        S_PAUSE1,
        S_PAUSE2
`endif
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_LD    = 4'b0010;
    localparam logic [3:0] OP_ST    = 4'b0011;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;
    localparam logic [3:0] OP_LEA   = 4'b1110;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_ADDER = 2'b01;
    localparam logic [1:0] PCMUX_BUS   = 2'b10;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mem_wait_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_ctr
// Description : Counts the cycles of one memory access; o_last marks the final
//               enabled cycle, after which the count wraps back to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_ctr #(
    parameter int MEM_WAIT = 3,
    parameter int CNT_W    = $clog2(MEM_WAIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clear,
    output logic o_last
);

    localparam logic [CNT_W-1:0] c_last_count = CNT_W'(MEM_WAIT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_last ? '0 : r_count + CNT_W'(1);
        end
    end

    assign o_last = i_en && (r_count == c_last_count);

endmodule
`default_nettype wire

// File: rtl/control_ws.sv
`default_nettype none
// ============================================================================
// Module      : control_ws
// Description : SLC-3 instruction-sequencing FSM with counted BRAM accesses.
//               Define CONTROL_WS_PAUSE_EN to enable the PAUSE (opcode 1101) states.
// Revision    : 1.0 - initial release
// ============================================================================
module control_ws
    import control_ws_pkg::*;
#(
    parameter int MEM_WAIT = 3,
    parameter int CNT_W    = $clog2(MEM_WAIT + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic        ben,
    input  logic        run_i,
    input  logic        continue_i,
    output logic        ld_mar,
    output logic        ld_mdr,
    output logic        ld_ir,
    output logic        ld_pc,
    output logic        ld_led,
    output logic        ld_reg,
    output logic        ld_ben,
    output logic        ld_cc,
    output logic        gate_pc,
    output logic        gate_mdr,
    output logic        gate_marmux,
    output logic        gate_alu,
    output logic        SR1_MUX_select,
    output logic        SR2_MUX_select,
    output logic        ADDR1_MUX_select,
    output logic [1:0]  ADDR2_MUX_select,
    output logic        DR_MUX_select,
    output logic [1:0]  PCMUX_select,
    output logic [1:0]  ALUK,
    output logic        mio_en,
    output logic        mem_mem_ena,
    output logic        mem_wr_ena,
    output logic        illegal_op
);

    state_t r_state;
    state_t w_next_state;
    logic   r_ret_data;   // 1: the pending read is a data load, not an instruction fetch
    logic   w_in_mem;
    logic   w_mem_last;

    assign w_in_mem = (r_state == S_RD) || (r_state == S_WR);

    mem_wait_ctr #(
        .MEM_WAIT (MEM_WAIT),
        .CNT_W    (CNT_W)
    ) u_mem_wait_ctr (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_in_mem),
        .i_clear (!w_in_mem),
        .o_last  (w_mem_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_HALTED;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (r_state == S_FETCH)) begin
            r_ret_data <= 1'b0;
        end else if ((r_state == S_LDR_ADDR) || (r_state == S_LD_ADDR)) begin
            r_ret_data <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_HALTED:   if (run_i) w_next_state = S_FETCH;
            S_FETCH:    w_next_state = S_RD;
            S_RD:       if (w_mem_last) w_next_state = r_ret_data ? S_LDREG : S_DEC_IR;
            S_DEC_IR:   w_next_state = S_DISPATCH;
            S_DISPATCH: begin
                case (ir[15:12])
                    OP_ADD:   w_next_state = S_ADD;
                    OP_AND:   w_next_state = S_AND;
                    OP_NOT:   w_next_state = S_NOT;
                    OP_BR:    w_next_state = ben ? S_BR_TAKE : S_FETCH;
                    OP_JMP:   w_next_state = S_JMP;
                    OP_JSR:   w_next_state = S_JSR_R7;
                    OP_LDR:   w_next_state = S_LDR_ADDR;
                    OP_LD:    w_next_state = S_LD_ADDR;
                    OP_STR:   w_next_state = S_STR_ADDR;
                    OP_ST:    w_next_state = S_ST_ADDR;
                    OP_LEA:   w_next_state = S_LEA;
`ifdef CONTROL_WS_PAUSE_EN
                    OP_PAUSE: w_next_state = S_PAUSE1;
`else
                    OP_PAUSE: w_next_state = S_ILLEGAL;
`endif
                    default:  w_next_state = S_ILLEGAL;
                endcase
            end
            S_JSR_R7:   w_next_state = ir[11] ? S_JSR_OFF : S_JSRR_BASE;
            S_LDR_ADDR, S_LD_ADDR: w_next_state = S_RD;
            S_STR_ADDR, S_ST_ADDR: w_next_state = S_STDATA;
            S_STDATA:   w_next_state = S_WR;
            S_WR:       if (w_mem_last) w_next_state = S_FETCH;
`ifdef CONTROL_WS_PAUSE_EN
            S_PAUSE1:   if (continue_i) w_next_state = S_PAUSE2;
            S_PAUSE2:   if (!continue_i) w_next_state = S_FETCH;
`endif
            default:    w_next_state = S_FETCH;
        endcase
    end

`ifndef CONTROL_WS_PAUSE_EN
    logic w_unused_continue;
    assign w_unused_continue = continue_i;
`endif
    logic w_unused_ir;
    assign w_unused_ir = ^{ir[10:6], ir[4:0]};

    always_comb begin
        ld_mar = 1'b0;  ld_mdr = 1'b0;  ld_ir = 1'b0;  ld_pc = 1'b0;
        ld_led = 1'b0;  ld_reg = 1'b0;  ld_ben = 1'b0; ld_cc = 1'b0;
        gate_pc = 1'b0; gate_mdr = 1'b0; gate_marmux = 1'b0; gate_alu = 1'b0;
        SR1_MUX_select   = 1'b0;
        SR2_MUX_select   = 1'b0;
        ADDR1_MUX_select = 1'b0;
        ADDR2_MUX_select = ADDR2_ZERO;
        DR_MUX_select    = 1'b0;
        PCMUX_select     = PCMUX_INC;
        ALUK             = ALUK_ADD;
        mio_en           = 1'b1;
        mem_mem_ena      = 1'b0;
        mem_wr_ena       = 1'b0;
        illegal_op       = 1'b0;
        case (r_state)
            S_FETCH:    begin gate_pc = 1'b1; ld_mar = 1'b1; ld_pc = 1'b1; end
            S_RD:       begin mem_mem_ena = 1'b1; ld_mdr = w_mem_last; end
            S_DEC_IR:   begin gate_mdr = 1'b1; ld_ir = 1'b1; end
            S_DISPATCH: ld_ben = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                ld_reg = 1'b1; ld_cc = 1'b1; gate_alu = 1'b1; SR1_MUX_select = 1'b1;
                SR2_MUX_select = (r_state == S_NOT) ? 1'b0 : ir[5];
                ALUK = (r_state == S_ADD) ? ALUK_ADD : (r_state == S_AND) ? ALUK_AND : ALUK_NOT;
            end
            S_BR_TAKE:  begin ADDR2_MUX_select = ADDR2_OFF9; PCMUX_select = PCMUX_ADDER; ld_pc = 1'b1; end
            S_JMP, S_JSRR_BASE: begin
                SR1_MUX_select = 1'b1; gate_alu = 1'b1; ALUK = ALUK_PASSA;
                PCMUX_select = PCMUX_BUS; ld_pc = 1'b1;
            end
            S_JSR_R7:   begin gate_pc = 1'b1; DR_MUX_select = 1'b1; ld_reg = 1'b1; end
            S_JSR_OFF:  begin ADDR2_MUX_select = ADDR2_OFF11; PCMUX_select = PCMUX_ADDER; ld_pc = 1'b1; end
            S_LDR_ADDR, S_STR_ADDR: begin
                SR1_MUX_select = 1'b1; ADDR1_MUX_select = 1'b1; ADDR2_MUX_select = ADDR2_OFF6;
                gate_marmux = 1'b1; ld_mar = 1'b1;
            end
            S_LD_ADDR, S_ST_ADDR: begin ADDR2_MUX_select = ADDR2_OFF9; gate_marmux = 1'b1; ld_mar = 1'b1; end
            S_LEA:      begin
                gate_marmux = 1'b1; ADDR2_MUX_select = ADDR2_OFF9; ld_reg = 1'b1; ld_cc = 1'b1;
            end
            S_ILLEGAL:  illegal_op = 1'b1;
            S_LDREG:    begin gate_mdr = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1; end
            // Store data is routed from SR (IR[11:9]) through the ALU onto the bus into MDR
            S_STDATA:   begin gate_alu = 1'b1; ALUK = ALUK_PASSA; mio_en = 1'b0; ld_mdr = 1'b1; end
            S_WR:       begin mem_mem_ena = 1'b1; mem_wr_ena = 1'b1; end
`ifdef CONTROL_WS_PAUSE_EN
            S_PAUSE1, S_PAUSE2: ld_led = 1'b1;
`endif
            default:    ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_ws.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_ws
// Description : Cycle-accurate vector bench for control_ws at MEM_WAIT 1, 3 and 5.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_control_ws;

    typedef struct packed {
        logic ld_mar, ld_mdr, ld_ir, ld_pc, ld_led, ld_reg, ld_ben, ld_cc;
        logic gate_pc, gate_mdr, gate_marmux, gate_alu;
        logic sr1, sr2, addr1;
        logic [1:0] addr2;
        logic dr;
        logic [1:0] pcmux;
        logic [1:0] aluk;
        logic mio_en, mem_ena, wr_ena, illegal;
    } ctl_t;

    typedef struct {
        string       nm;
        logic        rst;
        logic        run;
        logic        cont;
        logic        ben;
        logic [15:0] ir;
        ctl_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ir = '0;
    logic        ben = 1'b0;
    logic        run_i = 1'b0;
    logic        continue_i = 1'b0;

    wire ctl_t o1, o3, o5;

    vec_t  vec[$];
    ctl_t  sb[$];
    logic [15:0] cur_ir;
    logic        cur_ben;
    logic        cur_cont;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_ws #(.MEM_WAIT(1)) u_dut1 (
        .clk(clk), .reset(reset), .ir(ir), .ben(ben), .run_i(run_i), .continue_i(continue_i),
        .ld_mar(o1.ld_mar), .ld_mdr(o1.ld_mdr), .ld_ir(o1.ld_ir), .ld_pc(o1.ld_pc),
        .ld_led(o1.ld_led), .ld_reg(o1.ld_reg), .ld_ben(o1.ld_ben), .ld_cc(o1.ld_cc),
        .gate_pc(o1.gate_pc), .gate_mdr(o1.gate_mdr), .gate_marmux(o1.gate_marmux), .gate_alu(o1.gate_alu),
        .SR1_MUX_select(o1.sr1), .SR2_MUX_select(o1.sr2), .ADDR1_MUX_select(o1.addr1),
        .ADDR2_MUX_select(o1.addr2), .DR_MUX_select(o1.dr), .PCMUX_select(o1.pcmux), .ALUK(o1.aluk),
        .mio_en(o1.mio_en), .mem_mem_ena(o1.mem_ena), .mem_wr_ena(o1.wr_ena), .illegal_op(o1.illegal));

    control_ws #(.MEM_WAIT(3)) u_dut3 (
        .clk(clk), .reset(reset), .ir(ir), .ben(ben), .run_i(run_i), .continue_i(continue_i),
        .ld_mar(o3.ld_mar), .ld_mdr(o3.ld_mdr), .ld_ir(o3.ld_ir), .ld_pc(o3.ld_pc),
        .ld_led(o3.ld_led), .ld_reg(o3.ld_reg), .ld_ben(o3.ld_ben), .ld_cc(o3.ld_cc),
        .gate_pc(o3.gate_pc), .gate_mdr(o3.gate_mdr), .gate_marmux(o3.gate_marmux), .gate_alu(o3.gate_alu),
        .SR1_MUX_select(o3.sr1), .SR2_MUX_select(o3.sr2), .ADDR1_MUX_select(o3.addr1),
        .ADDR2_MUX_select(o3.addr2), .DR_MUX_select(o3.dr), .PCMUX_select(o3.pcmux), .ALUK(o3.aluk),
        .mio_en(o3.mio_en), .mem_mem_ena(o3.mem_ena), .mem_wr_ena(o3.wr_ena), .illegal_op(o3.illegal));

    control_ws #(.MEM_WAIT(5)) u_dut5 (
        .clk(clk), .reset(reset), .ir(ir), .ben(ben), .run_i(run_i), .continue_i(continue_i),
        .ld_mar(o5.ld_mar), .ld_mdr(o5.ld_mdr), .ld_ir(o5.ld_ir), .ld_pc(o5.ld_pc),
        .ld_led(o5.ld_led), .ld_reg(o5.ld_reg), .ld_ben(o5.ld_ben), .ld_cc(o5.ld_cc),
        .gate_pc(o5.gate_pc), .gate_mdr(o5.gate_mdr), .gate_marmux(o5.gate_marmux), .gate_alu(o5.gate_alu),
        .SR1_MUX_select(o5.sr1), .SR2_MUX_select(o5.sr2), .ADDR1_MUX_select(o5.addr1),
        .ADDR2_MUX_select(o5.addr2), .DR_MUX_select(o5.dr), .PCMUX_select(o5.pcmux), .ALUK(o5.aluk),
        .mio_en(o5.mio_en), .mem_mem_ena(o5.mem_ena), .mem_wr_ena(o5.wr_ena), .illegal_op(o5.illegal));

    // Expected-control builders, one per observable step of the sequencer
    function automatic ctl_t c_idle();
        ctl_t c = '0;
        c.mio_en = 1'b1;
        return c;
    endfunction

    function automatic ctl_t c_fetch();
        ctl_t c = c_idle();
        c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1;
        return c;
    endfunction

    function automatic ctl_t c_alu(input logic [1:0] k, input logic s2);
        ctl_t c = c_idle();
        c.ld_reg = 1'b1; c.ld_cc = 1'b1; c.gate_alu = 1'b1; c.sr1 = 1'b1; c.aluk = k; c.sr2 = s2;
        return c;
    endfunction

    function automatic ctl_t c_pc_from_base();
        ctl_t c = c_idle();
        c.sr1 = 1'b1; c.gate_alu = 1'b1; c.aluk = 2'b11; c.pcmux = 2'b10; c.ld_pc = 1'b1;
        return c;
    endfunction

    function automatic ctl_t c_mar(input logic base_reg);
        ctl_t c = c_idle();
        c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
        if (base_reg) begin c.sr1 = 1'b1; c.addr1 = 1'b1; c.addr2 = 2'b01; end
        else          c.addr2 = 2'b10;
        return c;
    endfunction

    function automatic void add(input string nm, input logic rst, input logic run, input ctl_t e);
        vec_t v;
        v.nm = nm; v.rst = rst; v.run = run; v.cont = cur_cont; v.ben = cur_ben; v.ir = cur_ir; v.exp = e;
        vec.push_back(v);
    endfunction

    function automatic void add_mem(input string nm, input int n, input logic wr);
        for (int k = 0; k < n; k++) begin
            ctl_t c = c_idle();
            c.mem_ena = 1'b1;
            c.wr_ena  = wr;
            c.ld_mdr  = !wr && (k == n - 1);
            add($sformatf("%s_%0d", nm, k), 1'b0, 1'b0, c);
        end
    endfunction

    function automatic void add_fetch_seq(input string nm, input int n);
        ctl_t c;
        add({nm, "_rst"}, 1'b1, 1'b0, c_idle());
        add({nm, "_fetch"}, 1'b0, 1'b1, c_fetch());
        add_mem({nm, "_ird"}, n, 1'b0);
        c = c_idle(); c.gate_mdr = 1'b1; c.ld_ir = 1'b1;
        add({nm, "_decir"}, 1'b0, 1'b1, c);
        c = c_idle(); c.ld_ben = 1'b1;
        add({nm, "_disp"}, 1'b0, 1'b0, c);
    endfunction

    task automatic run_vecs(input int sel);
        ctl_t got;
        ctl_t want;
        foreach (vec[i]) begin
            reset = vec[i].rst; run_i = vec[i].run; continue_i = vec[i].cont;
            ben = vec[i].ben; ir = vec[i].ir;
            sb.push_back(vec[i].exp);
            @(posedge clk);
            #1;
            got  = (sel == 1) ? o1 : (sel == 5) ? o5 : o3;
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL mw%0d %s: got %h required %h", sel, vec[i].nm, got, want);
            end
        end
        vec.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        ctl_t c;
        cur_ir = 16'h1283; cur_ben = 1'b0; cur_cont = 1'b0;

        add("por0", 1'b1, 1'b0, c_idle());
        add("por1", 1'b1, 1'b0, c_idle());
        add("halt_no_run", 1'b0, 1'b0, c_idle());
        add_fetch_seq("add", 3);
        add("add_exec", 1'b0, 1'b0, c_alu(2'b00, 1'b0));
        add("add_next", 1'b0, 1'b0, c_fetch());

        cur_ir = 16'h5262;
        add_fetch_seq("and", 3);
        add("and_exec", 1'b0, 1'b0, c_alu(2'b01, 1'b1));
        add("and_next", 1'b0, 1'b0, c_fetch());

        cur_ir = 16'h927F;
        add_fetch_seq("not", 3);
        add("not_exec", 1'b0, 1'b0, c_alu(2'b10, 1'b0));

        cur_ir = 16'h3005;
        add_fetch_seq("st", 3);
        add("st_addr", 1'b0, 1'b0, c_mar(1'b0));
        c = c_idle(); c.gate_alu = 1'b1; c.aluk = 2'b11; c.mio_en = 1'b0; c.ld_mdr = 1'b1;
        add("st_data", 1'b0, 1'b0, c);
        add_mem("st_wr", 3, 1'b1);
        add("st_next", 1'b0, 1'b0, c_fetch());

        cur_ir = 16'h7283;
        add_fetch_seq("str", 3);
        add("str_addr", 1'b0, 1'b0, c_mar(1'b1));

        cur_ir = 16'h0E02; cur_ben = 1'b0;
        add_fetch_seq("br_nt", 3);
        add("br_nt_next", 1'b0, 1'b0, c_fetch());
        cur_ben = 1'b1;
        add_fetch_seq("br_t", 3);
        c = c_idle(); c.addr2 = 2'b10; c.pcmux = 2'b01; c.ld_pc = 1'b1;
        add("br_take", 1'b0, 1'b0, c);
        add("br_t_next", 1'b0, 1'b0, c_fetch());
        cur_ben = 1'b0;

        cur_ir = 16'h4080;
        add_fetch_seq("jsrr", 3);
        c = c_idle(); c.gate_pc = 1'b1; c.dr = 1'b1; c.ld_reg = 1'b1;
        add("jsrr_r7", 1'b0, 1'b0, c);
        add("jsrr_pc", 1'b0, 1'b0, c_pc_from_base());
        add("jsrr_next", 1'b0, 1'b0, c_fetch());

        cur_ir = 16'h4803;
        add_fetch_seq("jsr", 3);
        c = c_idle(); c.gate_pc = 1'b1; c.dr = 1'b1; c.ld_reg = 1'b1;
        add("jsr_r7", 1'b0, 1'b0, c);
        c = c_idle(); c.addr2 = 2'b11; c.pcmux = 2'b01; c.ld_pc = 1'b1;
        add("jsr_pc", 1'b0, 1'b0, c);

        cur_ir = 16'hC1C0;
        add_fetch_seq("jmp", 3);
        add("jmp_pc", 1'b0, 1'b0, c_pc_from_base());

        cur_ir = 16'hE005;
        add_fetch_seq("lea", 3);
        c = c_idle(); c.gate_marmux = 1'b1; c.addr2 = 2'b10; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
        add("lea_exec", 1'b0, 1'b0, c);
        add("lea_next", 1'b0, 1'b0, c_fetch());

        cur_ir = 16'h2005;
        add_fetch_seq("ld", 3);
        add("ld_addr", 1'b0, 1'b0, c_mar(1'b0));
        add_mem("ld_drd", 3, 1'b0);
        c = c_idle(); c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
        add("ld_ldreg", 1'b0, 1'b0, c);
        add("ld_next", 1'b0, 1'b0, c_fetch());
        c = c_idle(); c.mem_ena = 1'b1;
        add("ld_refetch_rd", 1'b0, 1'b0, c);

        cur_ir = 16'h8000;
        add_fetch_seq("ill", 3);
        c = c_idle(); c.illegal = 1'b1;
        add("ill_pulse", 1'b0, 1'b0, c);
        add("ill_next", 1'b0, 1'b0, c_fetch());
        c = c_idle(); c.mem_ena = 1'b1;
        add("ill_gone", 1'b0, 1'b0, c);

        cur_ir = 16'hD000;
        add_fetch_seq("op_d", 3);
`ifdef CONTROL_WS_PAUSE_EN
        c = c_idle(); c.ld_led = 1'b1;
        add("pause1", 1'b0, 1'b0, c);
        add("pause1_hold", 1'b0, 1'b0, c);
        cur_cont = 1'b1;
        add("pause2", 1'b0, 1'b0, c);
        add("pause2_hold", 1'b0, 1'b0, c);
        cur_cont = 1'b0;
        add("pause_next", 1'b0, 1'b0, c_fetch());
`else
        c = c_idle(); c.illegal = 1'b1;
        add("op_d_illegal", 1'b0, 1'b0, c);
        add("op_d_next", 1'b0, 1'b0, c_fetch());
`endif

        // Reset arriving in the middle of a write window
        cur_ir = 16'h3005;
        add_fetch_seq("stx", 3);
        add("stx_addr", 1'b0, 1'b0, c_mar(1'b0));
        c = c_idle(); c.gate_alu = 1'b1; c.aluk = 2'b11; c.mio_en = 1'b0; c.ld_mdr = 1'b1;
        add("stx_data", 1'b0, 1'b0, c);
        c = c_idle(); c.mem_ena = 1'b1; c.wr_ena = 1'b1;
        add("stx_wr0", 1'b0, 1'b0, c);
        add("stx_wr1", 1'b0, 1'b0, c);
        add("stx_reset", 1'b1, 1'b0, c_idle());
        add("stx_after", 1'b0, 1'b0, c_idle());
        run_vecs(3);

        // Read-window length follows MEM_WAIT
        for (int m = 1; m <= 5; m += 4) begin
            cur_ir = 16'h6283;
            add_fetch_seq($sformatf("ldr%0d", m), m);
            add("ldr_addr", 1'b0, 1'b0, c_mar(1'b1));
            add_mem("ldr_drd", m, 1'b0);
            c = c_idle(); c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
            add("ldr_ldreg", 1'b0, 1'b0, c);
            add("ldr_next", 1'b0, 1'b0, c_fetch());
            run_vecs(m);
        end

        cur_ir = 16'h3005;
        add_fetch_seq("st1", 1);
        add("st1_addr", 1'b0, 1'b0, c_mar(1'b0));
        c = c_idle(); c.gate_alu = 1'b1; c.aluk = 2'b11; c.mio_en = 1'b0; c.ld_mdr = 1'b1;
        add("st1_data", 1'b0, 1'b0, c);
        add_mem("st1_wr", 1, 1'b1);
        add("st1_next", 1'b0, 1'b0, c_fetch());
        run_vecs(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
